// File: rtl/soc_test_status_pkg.sv
// soc_test_status_pkg: shared constants for the test-status / watchdog peripheral.
// Holds the register byte offsets, the FSM state encoding and the STATUS bit
// positions. Benches import it to decode STATUS.
package soc_test_status_pkg;

    // Register byte offsets inside the peripheral window
    localparam int unsigned REG_TOHOST    = 32'h00;
    localparam int unsigned REG_STATUS    = 32'h04;
    localparam int unsigned REG_CYCLE     = 32'h08;
    localparam int unsigned REG_SIGNATURE = 32'h0C;
    localparam int unsigned REG_LEDS      = 32'h10;
    localparam int unsigned REG_CONTROL   = 32'h14;

    // FSM state encoding; every state other than RUNNING is terminal and sticky
    localparam logic [1:0] ST_RUNNING = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STATUS_RUNNING_BIT = 0;
    localparam int unsigned STATUS_PASS_BIT    = 1;
    localparam int unsigned STATUS_FAIL_BIT    = 2;
    localparam int unsigned STATUS_TIMEOUT_BIT = 3;

endpackage

// File: rtl/soc_test_status_if.sv
// soc_test_status_if: single-cycle request / one-cycle ack register bus.
//   read, write   : one-cycle request strobes (never both high)
//   address       : byte offset, word aligned
//   write_data    : write payload
//   read_data     : read result, valid while ack is high, 0 otherwise
//   ack           : response one cycle after each request
interface soc_test_status_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ack;

    modport master (
        output read, write, address, write_data,
        input  read_data, ack
    );

    modport slave (
        input  read, write, address, write_data,
        output read_data, ack
    );
endinterface

// File: rtl/watchdog_counter.sv
// watchdog_counter: cycle counter that flags expiry at a fixed limit.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   i_enable      : count while high
//   i_kick        : clear the count (overrides expiry in the same cycle)
//   o_expired_c   : combinational; high in the cycle the count reaches LIMIT-1
// LIMIT of 0 disables expiry entirely.
module watchdog_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LIMIT = 600
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_kick,
    output logic o_expired_c
);

    localparam logic [WIDTH-1:0] LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);
    localparam logic             ARMED = (LIMIT != 0);

    logic [WIDTH-1:0] r_count;

    // Count register: kick restarts from zero
    always_ff @(posedge clk) begin
        if (reset || i_kick) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Expiry lands on the cycle whose edge would make the count reach LIMIT
    assign o_expired_c = ARMED && i_enable && !i_kick && (r_count == LAST);

endmodule

// File: rtl/soc_test_status.sv
// soc_test_status: memory-mapped test-status and watchdog peripheral.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   bus           : register bus slave (read/write/address/write_data -> read_data/ack)
//   done          : any terminal state reached
//   pass/fail     : TOHOST reported pass / failure
//   timeout       : watchdog expired while running
//   exit_code     : write_data[DATA_WIDTH-1:1] of the failing TOHOST write
//   leds          : low LED_WIDTH bits of the LEDS register
module soc_test_status
    import soc_test_status_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 600,
    parameter int unsigned LED_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    soc_test_status_if.slave      bus,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-2:0] exit_code,
    output logic [LED_WIDTH-1:0]  leds
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_fail;
    logic                  r_timeout;
    logic [DATA_WIDTH-2:0] r_exit_code;
    logic [DATA_WIDTH-1:0] r_tohost;
    logic [DATA_WIDTH-1:0] r_sig;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic [LED_WIDTH-1:0]  r_leds;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [DATA_WIDTH-1:0] w_read_mux;

    logic w_running;
    logic w_sel_tohost;
    logic w_sel_sig;
    logic w_sel_leds;
    logic w_sel_control;
    logic w_tohost_wr;
    logic w_terminal_wr;
    logic w_kick;
    logic w_expired;

    // Address decode and qualified write strobes
    assign w_running     = (r_state == ST_RUNNING);
    assign w_sel_tohost  = (bus.address == ADDR_WIDTH'(REG_TOHOST));
    assign w_sel_sig     = (bus.address == ADDR_WIDTH'(REG_SIGNATURE));
    assign w_sel_leds    = (bus.address == ADDR_WIDTH'(REG_LEDS));
    assign w_sel_control = (bus.address == ADDR_WIDTH'(REG_CONTROL));
    assign w_tohost_wr   = bus.write && w_sel_tohost && w_running;
    assign w_terminal_wr = w_tohost_wr && bus.write_data[0];
    assign w_kick        = bus.write && w_sel_control && bus.write_data[0] && w_running;

    watchdog_counter #(
        .WIDTH (DATA_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (w_running),
        .i_kick      (w_kick),
        .o_expired_c (w_expired)
    );

    // Next state: a terminal TOHOST write takes priority over watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        if (w_running) begin
            if (w_terminal_wr) begin
                w_state_nxt = (bus.write_data == DATA_WIDTH'(1)) ? ST_PASS : ST_FAIL;
            end else if (w_expired) begin
                w_state_nxt = ST_TIMEOUT;
            end
        end
    end

    // State register; status flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUNNING;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt != ST_RUNNING);
            r_pass    <= (w_state_nxt == ST_PASS);
            r_fail    <= (w_state_nxt == ST_FAIL);
            r_timeout <= (w_state_nxt == ST_TIMEOUT);
            if (w_terminal_wr && (w_state_nxt == ST_FAIL)) begin
                r_exit_code <= bus.write_data[DATA_WIDTH-1:1];
            end
        end
    end

    // Software-visible registers; CYCLE freezes once a terminal state is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tohost <= '0;
            r_sig    <= '0;
            r_cycle  <= '0;
            r_leds   <= '0;
        end else begin
            if (w_running) begin
                r_cycle <= r_cycle + DATA_WIDTH'(1);
            end
            if (w_tohost_wr) begin
                r_tohost <= bus.write_data;
            end
            if (bus.write && w_sel_sig) begin
                r_sig <= {r_sig[DATA_WIDTH-2:0], r_sig[DATA_WIDTH-1]} ^ bus.write_data;
            end
            if (bus.write && w_sel_leds) begin
                r_leds <= bus.write_data[LED_WIDTH-1:0];
            end
        end
    end

    // Read mux; unmapped and write-only offsets read as zero
    always_comb begin
        w_read_mux = '0;
        case (bus.address)
            ADDR_WIDTH'(REG_TOHOST):    w_read_mux = r_tohost;
            ADDR_WIDTH'(REG_STATUS): begin
                w_read_mux[STATUS_RUNNING_BIT] = w_running;
                w_read_mux[STATUS_PASS_BIT]    = r_pass;
                w_read_mux[STATUS_FAIL_BIT]    = r_fail;
                w_read_mux[STATUS_TIMEOUT_BIT] = r_timeout;
            end
            ADDR_WIDTH'(REG_CYCLE):     w_read_mux = r_cycle;
            ADDR_WIDTH'(REG_SIGNATURE): w_read_mux = r_sig;
            ADDR_WIDTH'(REG_LEDS):      w_read_mux[LED_WIDTH-1:0] = r_leds;
            default:                    w_read_mux = '0;
        endcase
    end

    // Bus response: every request is acked on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_ack       <= bus.read || bus.write;
            r_read_data <= bus.read ? w_read_mux : '0;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.read_data = r_read_data;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign timeout       = r_timeout;
    assign exit_code     = r_exit_code;
    assign leds          = r_leds;

endmodule

// File: tb/tb_soc_test_status.sv
// tb_soc_test_status: directed and randomized bench for soc_test_status.
// A behavioural model tracks edges since reset, the deadline set by the last
// kick, the terminal outcome and the register contents; every cycle the DUT
// outputs are compared against it.
module tb_soc_test_status;
    import soc_test_status_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned T  = 600;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          done;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [DW-2:0] exit_code;
    logic [LW-1:0] leds;

    soc_test_status_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    soc_test_status #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (T),
        .LED_WIDTH      (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .timeout   (timeout),
        .exit_code (exit_code),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    bit          m_pass, m_fail, m_to;
    int unsigned m_edge;      // edges since reset released
    int unsigned m_kick;      // edge of last kick (0 = reset)
    int unsigned m_frz;       // CYCLE value once terminal
    logic [31:0] m_tohost, m_sig;
    logic [7:0]  m_leds;
    logic [30:0] m_exit;
    logic        exp_ack;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] s;
        bit running;
        running = !(m_pass || m_fail || m_to);
        s = '0;
        case (a)
            5'h00: s = m_tohost;
            5'h04: begin
                s[STATUS_RUNNING_BIT] = running;
                s[STATUS_PASS_BIT]    = m_pass;
                s[STATUS_FAIL_BIT]    = m_fail;
                s[STATUS_TIMEOUT_BIT] = m_to;
            end
            5'h08: s = running ? m_edge : m_frz;
            5'h0C: s = m_sig;
            5'h10: s = {24'd0, m_leds};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Apply one clock edge to the model
    task automatic model_edge(input logic rst, input logic rd, input logic wr,
                              input logic [4:0] a, input logic [31:0] d);
        bit running, term, kick, expire;
        if (rst) begin
            m_pass = 0; m_fail = 0; m_to = 0;
            m_edge = 0; m_kick = 0; m_frz = 0;
            m_tohost = '0; m_sig = '0; m_leds = '0; m_exit = '0;
            exp_ack = 1'b0; exp_rdata = '0;
            return;
        end
        exp_ack   = rd || wr;
        exp_rdata = rd ? model_read(a) : 32'd0;
        m_edge    = m_edge + 1;
        running   = !(m_pass || m_fail || m_to);
        if (running) begin
            term   = wr && (a == 5'h00) && d[0];
            kick   = wr && (a == 5'h14) && d[0];
            expire = (T != 0) && !kick && (m_edge == m_kick + T);
            if (wr && a == 5'h00) m_tohost = d;
            if (term) begin
                if (d == 32'd1) m_pass = 1;
                else begin
                    m_fail = 1;
                    m_exit = d[31:1];
                end
            end else if (expire) begin
                m_to = 1;
            end
            if (kick) m_kick = m_edge;
            if (m_pass || m_fail || m_to) m_frz = m_edge;
        end
        if (wr && a == 5'h0C) m_sig = {m_sig[30:0], m_sig[31]} ^ d;
        if (wr && a == 5'h10) m_leds = d[7:0];
    endtask

    task automatic check_all();
        chk("ack",       {31'd0, bus.ack}, {31'd0, exp_ack});
        chk("read_data", bus.read_data, exp_rdata);
        chk("done",      {31'd0, done}, {31'd0, (m_pass || m_fail || m_to)});
        chk("pass",      {31'd0, pass}, {31'd0, m_pass});
        chk("fail",      {31'd0, fail}, {31'd0, m_fail});
        chk("timeout",   {31'd0, timeout}, {31'd0, m_to});
        chk("exit_code", {1'b0, exit_code}, {1'b0, m_exit});
        chk("leds",      {24'd0, leds}, {24'd0, m_leds});
    endtask

    // Drive one cycle at the falling edge, check #1 after the rising edge
    task automatic tick(input logic rst, input logic rd, input logic wr,
                        input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reset          = rst;
        bus.read       = rd;
        bus.write      = wr;
        bus.address    = a;
        bus.write_data = d;
        model_edge(rst, rd, wr, a, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
        tick(1'b1, 1'b0, 1'b0, 5'h00, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 5'h00, 32'd0);
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        tick(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [4:0] a);
        tick(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    initial begin
        int unsigned op;
        logic [4:0]  a;
        logic [31:0] d;

        reset = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.write_data = '0;

        // Reset state
        do_reset();
        chk("reset_done", {31'd0, done}, 32'd0);
        rd_reg(5'(REG_STATUS));
        chk("reset_status", bus.read_data, 32'd1 << STATUS_RUNNING_BIT);

        // Pass at edge 10, CYCLE frozen at 10
        do_reset();
        idle(9);
        wr_reg(5'(REG_TOHOST), 32'd1);
        chk("pass_edge10", {30'd0, pass, done}, 32'd3);
        rd_reg(5'(REG_CYCLE));
        chk("cycle_frozen", bus.read_data, 32'd10);
        idle(5);
        rd_reg(5'(REG_CYCLE));
        chk("cycle_still_frozen", bus.read_data, 32'd10);

        // Fail with exit code, later pass write ignored
        do_reset();
        wr_reg(5'(REG_TOHOST), 32'h0000_002B);
        chk("fail_code", {1'b0, exit_code}, 32'd21);
        wr_reg(5'(REG_TOHOST), 32'd1);
        chk("fail_sticky", {30'd0, fail, pass}, 32'd2);
        rd_reg(5'(REG_TOHOST));
        chk("tohost_frozen", bus.read_data, 32'h0000_002B);

        // Signature rotate-xor, even TOHOST value stored without state change
        do_reset();
        wr_reg(5'(REG_SIGNATURE), 32'h8000_0001);
        wr_reg(5'(REG_SIGNATURE), 32'h0000_0001);
        rd_reg(5'(REG_SIGNATURE));
        chk("signature", bus.read_data, 32'h0000_0002);
        wr_reg(5'(REG_TOHOST), 32'h0000_1234);
        rd_reg(5'(REG_TOHOST));
        chk("tohost_even", bus.read_data, 32'h0000_1234);

        // Timeout exactly T cycles after reset release
        do_reset();
        idle(T - 1);
        chk("timeout_early", {31'd0, timeout}, 32'd0);
        idle(1);
        chk("timeout_exact", {31'd0, timeout}, 32'd1);
        wr_reg(5'(REG_LEDS), 32'h0000_01A5);
        chk("leds_in_terminal", {24'd0, leds}, 32'h0000_00A5);

        // Kicks every 500 cycles keep the watchdog quiet
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle(499);
            wr_reg(5'(REG_CONTROL), 32'd1);
        end
        idle(100);
        chk("kicked_no_timeout", {31'd0, timeout}, 32'd0);

        // Kick in the expiry cycle wins and restarts the count
        do_reset();
        idle(T - 1);
        wr_reg(5'(REG_CONTROL), 32'd1);
        chk("kick_at_expiry", {31'd0, timeout}, 32'd0);
        idle(T - 1);
        chk("kick_restart_early", {31'd0, timeout}, 32'd0);
        idle(1);
        chk("kick_restart_exact", {31'd0, timeout}, 32'd1);

        // Pass write in the expiry cycle wins
        do_reset();
        idle(T - 1);
        wr_reg(5'(REG_TOHOST), 32'd1);
        chk("pass_beats_timeout", {30'd0, timeout, pass}, 32'd1);

        // LEDS truncation, unmapped read
        do_reset();
        wr_reg(5'(REG_LEDS), 32'h0000_01A5);
        chk("leds", {24'd0, leds}, 32'h0000_00A5);
        rd_reg(5'h1C);
        chk("unmapped_ack", {31'd0, bus.ack}, 32'd1);
        chk("unmapped_data", bus.read_data, 32'd0);

        // Reset one cycle after a read, and reset with a read in flight
        wr_reg(5'(REG_TOHOST), 32'h0000_0003);
        rd_reg(5'(REG_STATUS));
        tick(1'b1, 1'b1, 1'b0, 5'(REG_STATUS), 32'd0);
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_outs", {2'd0, leds, exit_code[21:0]}, 32'd0);
        chk("rst_flags", {28'd0, done, pass, fail, timeout}, 32'd0);
        rd_reg(5'(REG_STATUS));
        chk("rst_running", bus.read_data, 32'd1 << STATUS_RUNNING_BIT);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 99);
            a  = 5'($urandom_range(0, 7) * 4);
            d  = $urandom;
            if (a == 5'h00) begin
                if ($urandom_range(0, 39) == 0) d = ($urandom_range(0, 1) != 0) ? 32'd1 : (d | 32'd1);
                else d = d & ~32'd1;
            end
            if (op < 1)        tick(1'b1, 1'b0, 1'b0, a, d);
            else if (op < 30)  tick(1'b0, 1'b0, 1'b0, a, d);
            else if (op < 60)  tick(1'b0, 1'b1, 1'b0, a, d);
            else               tick(1'b0, 1'b0, 1'b1, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
